sram_bus_ctrl: RTL and testbench

SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_byte_merge.sv | 22 ++
 rtl/sram_bus_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_bus_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM bus controller: widths and FSM state encoding.
package sram_ctrl_pkg;

  localparam int unsigned AddrWDefault = 10;
  localparam int unsigned DataW        = 32;
  localparam int unsigned StrbW        = DataW / 8;

  // Controller states; kept as plain constants so older code can share the encoding.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRd     = 3'd1;
  localparam logic [2:0] StRdWait = 3'd2;
  localparam logic [2:0] StWr     = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  localparam logic [StrbW-1:0] StrbFull = '1;

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge: each byte comes from the new word when its strobe is set,
// otherwise from the old word read back from the SRAM.
module sram_byte_merge
  import sram_ctrl_pkg::*;
(
  input  logic [DataW-1:0] old_word_i,
  input  logic [DataW-1:0] new_word_i,
  input  logic [StrbW-1:0] strb_i,
  output logic [DataW-1:0] merged_o
);

  // Per-lane select between stored and incoming data.
  always_comb begin
    merged_o = old_word_i;
    for (int i = 0; i < int'(StrbW); i++) begin
      if (strb_i[i]) begin
        merged_o[8*i +: 8] = new_word_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// CPU-bus to synchronous SRAM controller. Full-word writes go straight to the
// array; reads and partial writes first read the word, partial writes then
// write back a byte-merged word. Every output is driven from a flop.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [DataW-1:0]  mem_wdata,
  input  logic [StrbW-1:0]  mem_wstrb,
  output logic [DataW-1:0]  mem_rdata,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DataW-1:0]  sram_D,
  output logic              sram_CEn,
  output logic              sram_WEn,
  output logic              sram_OEn,
  input  logic [DataW-1:0]  sram_Q
);

  logic [2:0]        state_q, state_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;
  logic              ready_q, ready_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DataW-1:0]  dout_q, dout_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic [DataW-1:0]  merged;

  // Byte lanes and word-offset bits outside the SRAM range are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  sram_byte_merge u_merge (
    .old_word_i (sram_Q),
    .new_word_i (wdata_q),
    .strb_i     (wstrb_q),
    .merged_o   (merged)
  );

  // Next-state and next-output decode for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    cen_d   = cen_q;
    wen_d   = wen_q;
    oen_d   = oen_q;
    case (state_q)
      StIdle: begin
        if (mem_valid) begin
          addr_d  = mem_addr[ADDR_W+1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cen_d   = 1'b0;
          if (mem_wstrb == StrbFull) begin
            state_d = StWr;
            wen_d   = 1'b0;
            oen_d   = 1'b1;
            dout_d  = mem_wdata;
          end else begin
            state_d = StRd;
            wen_d   = 1'b1;
            oen_d   = 1'b0;
          end
        end
      end
      StRd: begin
        // Keep the chip enabled so the registered Q survives into the next cycle.
        state_d = StRdWait;
        oen_d   = 1'b1;
      end
      StRdWait: begin
        if (wstrb_q == '0) begin
          rdata_d = sram_Q;
          ready_d = 1'b1;
          cen_d   = 1'b1;
          state_d = StResp;
        end else begin
          dout_d  = merged;
          wen_d   = 1'b0;
          state_d = StWr;
        end
      end
      StWr: begin
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        ready_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        oen_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset parks the SRAM deselected.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign sram_A    = addr_q;
  assign sram_D    = dout_q;
  assign sram_CEn  = cen_q;
  assign sram_WEn  = wen_q;
  assign sram_OEn  = oen_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl with a behavioural synchronous SRAM.
module tb_sram_bus_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [9:0]  sram_A;
  logic [31:0] sram_D;
  logic        sram_CEn;
  logic        sram_WEn;
  logic        sram_OEn;
  logic [31:0] sram_Q;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [0:1023];
  logic [31:0] rdq [$];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  sram_bus_ctrl #(.ADDR_W(10)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .sram_A    (sram_A),
    .sram_D    (sram_D),
    .sram_CEn  (sram_CEn),
    .sram_WEn  (sram_WEn),
    .sram_OEn  (sram_OEn),
    .sram_Q    (sram_Q)
  );

  // Synchronous SRAM: registered read, full-word write, sampled on the rising edge.
  logic [31:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (!sram_CEn) begin
      if (!sram_WEn) sram_mem[sram_A] <= sram_D;
      else           sram_Q <= sram_mem[sram_A];
    end
  end

  // Protocol monitor active through every test.
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    checks++;
    if (!sram_WEn && !sram_OEn) begin
      errors++;
      $display("FAIL we_oe_overlap: WEn=%b OEn=%b, required not both 0", sram_WEn, sram_OEn);
    end
    checks++;
    if (mem_ready && ready_prev) begin
      errors++;
      $display("FAIL ready_width: mem_ready high two cycles in a row, required one");
    end
    ready_prev <= mem_ready;
  end

  // One bus transaction, entered just after an edge with the DUT idle.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit keep_valid, input string tag);
    logic [9:0]  idx;
    logic [31:0] merged;
    logic [31:0] exp_rd;
    bit          is_rd;
    bit          full;
    int          exp_lat;
    int          lat;
    idx     = addr[11:2];
    is_rd   = (wstrb == 4'h0);
    full    = (wstrb == 4'hF);
    exp_lat = full ? 1 : (is_rd ? 2 : 3);
    if (is_rd) begin
      rdq.push_back(exp_mem[idx]);
    end else begin
      merged = exp_mem[idx];
      for (int b = 0; b < 4; b++) if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      exp_mem[idx] = merged;
    end
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    @(posedge clk); #1;
    if (!keep_valid) begin
      mem_valid = 1'b0;
      mem_addr  = 32'h5A5A_5A5A;
      mem_wdata = 32'hA5A5_A5A5;
      mem_wstrb = 4'h0;
    end
    checks++;
    if (sram_A !== idx || sram_CEn !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: sram_A=%h CEn=%b, required %h 0", tag, sram_A, sram_CEn, idx);
    end
    checks++;
    if (sram_WEn !== !full || sram_OEn !== full) begin
      errors++;
      $display("FAIL %s ctl: WEn=%b OEn=%b, required %b %b", tag, sram_WEn, sram_OEn,
               !full, full);
    end
    if (full) begin
      checks++;
      if (sram_D !== wdata) begin
        errors++;
        $display("FAIL %s sram_d: got %h, required %h", tag, sram_D, wdata);
      end
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (mem_ready !== 1'b1 && lat < 8);
    checks++;
    if (mem_ready !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: ready=%b after %0d edges, required 1 after %0d", tag,
               mem_ready, lat, exp_lat);
    end
    if (is_rd) begin
      exp_rd = rdq.pop_front();
      checks++;
      if (mem_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %h, required %h", tag, mem_rdata, exp_rd);
      end
      last_rdata = exp_rd;
    end else begin
      checks++;
      if (mem_rdata !== last_rdata) begin
        errors++;
        $display("FAIL %s rdata_hold: got %h, required %h", tag, mem_rdata, last_rdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (mem_ready !== 1'b0 || sram_CEn !== 1'b1) begin
      errors++;
      $display("FAIL %s resp: ready=%b CEn=%b, required 0 1", tag, mem_ready, sram_CEn);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || sram_A !== 10'h0 || sram_D !== 32'h0) begin
      errors++;
      $display("FAIL %s data: ready=%b rdata=%h A=%h D=%h, required 0 0 0 0", tag,
               mem_ready, mem_rdata, sram_A, sram_D);
    end
    checks++;
    if (sram_CEn !== 1'b1 || sram_WEn !== 1'b1 || sram_OEn !== 1'b1) begin
      errors++;
      $display("FAIL %s ctl: CEn=%b WEn=%b OEn=%b, required 1 1 1", tag, sram_CEn,
               sram_WEn, sram_OEn);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn     = 1'b1;
    last_rdata = 32'h0;
  endtask

  task automatic test_full_write_read();
    do_req(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "full_wr");
    do_req(32'h10, 32'h0, 4'h0, 1'b0, "full_rd");
    checks++;
    if (mem_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_rd_const: got %h, required deadbeef", mem_rdata);
    end
  endtask

  task automatic test_partial_write();
    do_req(32'h20, 32'h1122_3344, 4'hF, 1'b0, "pw_init");
    do_req(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, "pw_merge");
    do_req(32'h20, 32'h0, 4'h0, 1'b0, "pw_rd");
    checks++;
    if (mem_rdata !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL pw_const: got %h, required 11bb33dd", mem_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_req(32'h0, 32'hA5A5_0000, 4'hF, 1'b0, "b2b_init0");
    do_req(32'hFFC, 32'h0000_FFFF, 4'hF, 1'b0, "b2b_init1");
    do_req(32'h0, 32'h0, 4'h0, 1'b1, "b2b_rd0");
    do_req(32'hFFC, 32'h0, 4'h0, 1'b1, "b2b_rd1");
    mem_valid = 1'b0;
  endtask

  task automatic test_addr_ignore();
    do_req(32'h0000_1004, 32'h0102_0304, 4'hF, 1'b0, "hi_addr_wr");
    do_req(32'h0000_0004, 32'h0, 4'h0, 1'b0, "hi_addr_rd");
    checks++;
    if (mem_rdata !== 32'h0102_0304) begin
      errors++;
      $display("FAIL hi_addr_const: got %h, required 01020304", mem_rdata);
    end
  endtask

  task automatic test_reset_abort();
    do_req(32'h40, 32'h1234_5678, 4'hF, 1'b0, "abort_init");
    mem_valid = 1'b1;
    mem_addr  = 32'h40;
    mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'hF;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    checks++;
    if (sram_WEn !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_wr: WEn=%b, required 0", sram_WEn);
    end
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_ready !== 1'b0) begin
        errors++;
        $display("FAIL abort_ready: got %b, required 0", mem_ready);
      end
    end
    resetn     = 1'b1;
    last_rdata = 32'h0;
    // First edge after release must accept; do_req checks CEn at that edge.
    do_req(32'h40, 32'h0, 4'h0, 1'b0, "abort_rd");
    checks++;
    if (mem_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL abort_const: got %h, required 12345678", mem_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_back_to_back();
    test_addr_ignore();
    test_reset_abort();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
